// File: rtl/pipe_reg_ifid_pkg.sv
// pipe_reg_ifid_pkg
// Shared definitions for the IF/ID pipeline register:
//   - default field widths and the default NOP instruction word
//   - INST_TYPE_NONE, the type code shown on the ID side while no entry is held
//   - ifid_state_t, the occupancy states of the two-entry skid buffer
// No ports; imported by pipe_reg_ifid and pipe_reg_ifid_sat_counter.
package pipe_reg_ifid_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 4;
    localparam int PERF_W_DEF = 16;

    localparam logic [31:0] NOP_INST_DEF   = 32'h0000_0000;
    localparam logic [3:0]  INST_TYPE_NONE = 4'h0;

    typedef enum logic [1:0] {
        IFID_EMPTY = 2'd0,
        IFID_ONE   = 2'd1,
        IFID_TWO   = 2'd2
    } ifid_state_t;

endpackage

// File: rtl/pipe_reg_ifid_sat_counter.sv
// pipe_reg_ifid_sat_counter (sat_counter)
// Saturating event counter used for the IF/ID performance statistics.
// Ports:
//   clock    in   1      posedge clock
//   clear_n  in   1      synchronous active-low clear
//   inc      in   1      count one event this cycle
//   count    out  WIDTH  current count, sticks at all-ones
module pipe_reg_ifid_sat_counter
    import pipe_reg_ifid_pkg::*;
#(
    parameter int WIDTH = PERF_W_DEF
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc but never wrap; once all-ones the value is held.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_reg_ifid.sv
// pipe_reg_ifid
// IF/ID pipeline register with a two-entry skid buffer. The main entry drives
// the ID side, the skid entry catches the one fetch that arrives while ID
// stalls, so in_ready never depends combinationally on out_ready. A taken
// branch (flush) empties both entries and drops any same-cycle fetch.
// Optional feature: define PIPE_IFID_PERF_EN to build the stall/flush
// performance counters; otherwise perf_stall/perf_flush are tied to 0.
// Ports:
//   clock, reset (sync, active-low), flush
//   in_valid/in_ready, in_pc, in_new_pc, in_inst, in_inst_num, in_inst_type
//   out_valid/out_ready, out_pc, out_new_pc, out_inst, out_inst_num, out_inst_type
//   perf_stall, perf_flush (PERF_W wide)
module pipe_reg_ifid
    import pipe_reg_ifid_pkg::*;
#(
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter int                 TAG_W    = TAG_W_DEF,
    parameter logic [DATA_W-1:0]  NOP_INST = DATA_W'(NOP_INST_DEF),
    parameter int                 PERF_W   = PERF_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_new_pc,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [TAG_W-1:0]  in_inst_num,
    input  logic [TAG_W-1:0]  in_inst_type,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_new_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic [TAG_W-1:0]  out_inst_num,
    output logic [TAG_W-1:0]  out_inst_type,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush
);

    ifid_state_t state;
    ifid_state_t state_next;

    logic [DATA_W-1:0] main_pc, main_new_pc, main_inst;
    logic [TAG_W-1:0]  main_num, main_type;
    logic [DATA_W-1:0] skid_pc, skid_new_pc, skid_inst;
    logic [TAG_W-1:0]  skid_num, skid_type;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign out_valid = (state != IFID_EMPTY);
    assign in_fire   = in_valid & in_ready & ~flush;
    assign out_fire  = out_valid & out_ready;

    // Occupancy transitions. Flush wins over everything and the fetch
    // arriving with it is on the wrong path, so it is never loaded.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = IFID_EMPTY;
        end else begin
            case (state)
                IFID_EMPTY: begin
                    if (in_fire) begin
                        state_next   = IFID_ONE;
                        load_main_in = 1'b1;
                    end
                end
                IFID_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_next = IFID_TWO;
                        load_skid  = 1'b1;
                    end else if (out_fire) begin
                        state_next = IFID_EMPTY;
                    end
                end
                IFID_TWO: begin
                    if (out_fire) begin
                        state_next     = IFID_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = IFID_EMPTY;
            endcase
        end
    end

    // Control state. in_ready is registered from the next state so IF sees
    // a clean flop output rather than a path through out_ready.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IFID_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != IFID_TWO);
        end
    end

    // Entry payloads carry no reset; their contents are only visible while
    // out_valid is high, and the occupancy state is always reset.
    always_ff @(posedge clock) begin
        if (load_main_in) begin
            main_pc     <= in_pc;
            main_new_pc <= in_new_pc;
            main_inst   <= in_inst;
            main_num    <= in_inst_num;
            main_type   <= in_inst_type;
        end else if (load_main_skid) begin
            main_pc     <= skid_pc;
            main_new_pc <= skid_new_pc;
            main_inst   <= skid_inst;
            main_num    <= skid_num;
            main_type   <= skid_type;
        end
        if (load_skid) begin
            skid_pc     <= in_pc;
            skid_new_pc <= in_new_pc;
            skid_inst   <= in_inst;
            skid_num    <= in_inst_num;
            skid_type   <= in_inst_type;
        end
    end

    // ID side sees a NOP bubble whenever nothing valid is held.
    always_comb begin
        out_pc        = '0;
        out_new_pc    = '0;
        out_inst      = NOP_INST;
        out_inst_num  = '0;
        out_inst_type = TAG_W'(INST_TYPE_NONE);
        if (out_valid) begin
            out_pc        = main_pc;
            out_new_pc    = main_new_pc;
            out_inst      = main_inst;
            out_inst_num  = main_num;
            out_inst_type = main_type;
        end
    end

`ifdef PIPE_IFID_PERF_EN
    logic stall_inc;
    logic flush_inc;

    // A flush only counts when it actually threw away a held entry.
    assign stall_inc = out_valid & ~out_ready;
    assign flush_inc = flush & out_valid;

    pipe_reg_ifid_sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
        .clock   (clock),
        .clear_n (reset),
        .inc     (stall_inc),
        .count   (perf_stall)
    );

    pipe_reg_ifid_sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
        .clock   (clock),
        .clear_n (reset),
        .inc     (flush_inc),
        .count   (perf_flush)
    );
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_ifid.sv
// tb_pipe_reg_ifid
// Self-checking bench for pipe_reg_ifid. A queue-based occupancy model
// (at most two entries, oldest presented to ID) predicts every output each
// cycle. Works with or without PIPE_IFID_PERF_EN.
module tb_pipe_reg_ifid;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int PERF_W = 2;
    localparam int PERF_MAX = (1 << PERF_W) - 1;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [3:0]  TYPE_NONE = 4'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] new_pc;
        logic [31:0] inst;
        logic [3:0]  num;
        logic [3:0]  typ;
    } entry_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_pc = '0;
    logic [DATA_W-1:0] in_new_pc = '0;
    logic [DATA_W-1:0] in_inst = '0;
    logic [TAG_W-1:0]  in_inst_num = '0;
    logic [TAG_W-1:0]  in_inst_type = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_new_pc;
    logic [DATA_W-1:0] out_inst;
    logic [TAG_W-1:0]  out_inst_num;
    logic [TAG_W-1:0]  out_inst_type;
    logic [PERF_W-1:0] perf_stall;
    logic [PERF_W-1:0] perf_flush;

    int checks = 0;
    int errors = 0;

    entry_t model_q[$];
    int     model_stall = 0;
    int     model_flush = 0;

    pipe_reg_ifid #(
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W),
        .NOP_INST (NOP_WORD),
        .PERF_W   (PERF_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_new_pc     (in_new_pc),
        .in_inst       (in_inst),
        .in_inst_num   (in_inst_num),
        .in_inst_type  (in_inst_type),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_new_pc    (out_new_pc),
        .out_inst      (out_inst),
        .out_inst_num  (out_inst_num),
        .out_inst_type (out_inst_type),
        .perf_stall    (perf_stall),
        .perf_flush    (perf_flush)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // One comparison: count it and report a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance the reference model by one clock edge using the inputs that
    // were present at that edge.
    task automatic modelStep();
        entry_t e;
        bit     had_entry;
        bit     can_take;
        had_entry = (model_q.size() > 0);
        can_take  = (model_q.size() < 2);
        if (!reset) begin
            model_q.delete();
            model_stall = 0;
            model_flush = 0;
        end else begin
            if (had_entry && !out_ready && model_stall < PERF_MAX)
                model_stall++;
            if (flush) begin
                if (had_entry && model_flush < PERF_MAX)
                    model_flush++;
                model_q.delete();
            end else begin
                if (had_entry && out_ready)
                    void'(model_q.pop_front());
                if (in_valid && can_take) begin
                    e.pc     = in_pc;
                    e.new_pc = in_new_pc;
                    e.inst   = in_inst;
                    e.num    = in_inst_num;
                    e.typ    = in_inst_type;
                    model_q.push_back(e);
                end
            end
        end
    endtask

    // Compare every DUT output against the model.
    task automatic compareAll(input string tag);
        int exp_stall;
        int exp_flush;
`ifdef PIPE_IFID_PERF_EN
        exp_stall = model_stall;
        exp_flush = model_flush;
`else
        exp_stall = 0;
        exp_flush = 0;
`endif
        checkOutput({tag, "/in_ready"}, 64'(in_ready), 64'(model_q.size() < 2));
        checkOutput({tag, "/out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            checkOutput({tag, "/pc"}, 64'(out_pc), 64'(model_q[0].pc));
            checkOutput({tag, "/new_pc"}, 64'(out_new_pc), 64'(model_q[0].new_pc));
            checkOutput({tag, "/inst"}, 64'(out_inst), 64'(model_q[0].inst));
            checkOutput({tag, "/num"}, 64'(out_inst_num), 64'(model_q[0].num));
            checkOutput({tag, "/type"}, 64'(out_inst_type), 64'(model_q[0].typ));
        end else begin
            checkOutput({tag, "/pc"}, 64'(out_pc), 64'd0);
            checkOutput({tag, "/new_pc"}, 64'(out_new_pc), 64'd0);
            checkOutput({tag, "/inst"}, 64'(out_inst), 64'(NOP_WORD));
            checkOutput({tag, "/num"}, 64'(out_inst_num), 64'd0);
            checkOutput({tag, "/type"}, 64'(out_inst_type), 64'(TYPE_NONE));
        end
        checkOutput({tag, "/perf_stall"}, 64'(perf_stall), 64'(exp_stall));
        checkOutput({tag, "/perf_flush"}, 64'(perf_flush), 64'(exp_flush));
    endtask

    // Drive one cycle of inputs, clock it, update the model and check.
    task automatic applyStimulus(input string tag, input logic rst_n, input logic fl,
                                 input logic iv, input logic [31:0] pc,
                                 input logic [3:0] num, input logic ordy);
        reset        = rst_n;
        flush        = fl;
        in_valid     = iv;
        in_pc        = pc;
        in_new_pc    = pc + 32'd4;
        in_inst      = $urandom;
        in_inst_num  = num;
        in_inst_type = 4'($urandom_range(1, 15));
        out_ready    = ordy;
        @(posedge clock);
        modelStep();
        #1;
        compareAll(tag);
    endtask

    // Directed scenarios first, then a randomized soak.
    initial begin
        int exp_sat;

        // Reset then idle
        applyStimulus("reset", 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b1);
        applyStimulus("reset", 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b1);
        applyStimulus("idle", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b1);

        // Streaming pc 0..7 at full rate
        for (int i = 0; i < 8; i++)
            applyStimulus("stream", 1'b1, 1'b0, 1'b1, 32'(i), 4'(i), 1'b1);
        applyStimulus("stream_tail", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b1);
        applyStimulus("stream_tail", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b1);

        // Stall: pc 10, 11 accepted with ID stalled, then drain
        applyStimulus("stall", 1'b1, 1'b0, 1'b1, 32'd10, 4'd1, 1'b0);
        applyStimulus("stall", 1'b1, 1'b0, 1'b1, 32'd11, 4'd2, 1'b0);
        applyStimulus("stall_full", 1'b1, 1'b0, 1'b1, 32'd99, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall_drain", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b1);

        // Flush while full with a same-cycle fetch of pc 12
        applyStimulus("pre_flush", 1'b1, 1'b0, 1'b1, 32'd20, 4'd4, 1'b0);
        applyStimulus("pre_flush", 1'b1, 1'b0, 1'b1, 32'd21, 4'd5, 1'b0);
        applyStimulus("flush", 1'b1, 1'b1, 1'b1, 32'd12, 4'd6, 1'b0);
        applyStimulus("post_flush", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b1);

        // Instruction number wrap F -> 0
        applyStimulus("wrap", 1'b1, 1'b0, 1'b1, 32'd30, 4'hF, 1'b1);
        applyStimulus("wrap", 1'b1, 1'b0, 1'b1, 32'd31, 4'h0, 1'b1);
        applyStimulus("wrap_tail", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b1);

        // Reset while full
        applyStimulus("pre_rst", 1'b1, 1'b0, 1'b1, 32'd40, 4'd7, 1'b0);
        applyStimulus("pre_rst", 1'b1, 1'b0, 1'b1, 32'd41, 4'd8, 1'b0);
        applyStimulus("rst_full", 1'b0, 1'b0, 1'b1, 32'd42, 4'd9, 1'b0);

        // Perf saturation: one entry held for 5 stalled cycles
        applyStimulus("sat_load", 1'b1, 1'b0, 1'b1, 32'd50, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus("sat_stall", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
`ifdef PIPE_IFID_PERF_EN
        exp_sat = 3;
`else
        exp_sat = 0;
`endif
        checkOutput("perf_saturated", 64'(perf_stall), 64'(exp_sat));

        // Randomized soak
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random",
                          ($urandom_range(0, 40) != 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 2) != 0),
                          $urandom,
                          4'($urandom),
                          ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
